frame_config_writer: RTL and testbench
======================================

// Module: frame_config_writer
// PURPOSE
//  Writer side of the tile configuration-frame interface.
//  - Accepts a 32-bit configuration word stream: one header, then NumberOfRows row words.
//  - Assembles one frame and drives the fabric-wide FrameData bus.
//  - Pulses exactly one FrameStrobe line so the target column's tile ConfigMem latches can capture the frame.
//  - Sits between the bitstream loader (UART/USB word source) and the fabric frame buses.
// PARAMETERS
//  FrameBitsPerRow  32  data bits per row per frame; equals the stream word width
//  MaxFramesPerCol  20  frames per column, i.e. strobe lines per column (<=256)
//  NumberOfRows     16  tile rows; data words per frame
//  NumberOfCols      8  tile columns (<=256)
//  StrobeCycles      1  cycles FrameStrobe is held high (>=1)
// PORTS
//  CLK              in   1                               system clock, rising edge
//  RESET            in   1                               async reset, active high
//  s_data           in   32                              stream word
//  s_valid          in   1                               s_data valid
//  s_ready          out  1                               writer accepts s_data this cycle
//  FrameData        out  NumberOfRows*FrameBitsPerRow    frame data, row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//  FrameStrobe      out  NumberOfCols*MaxFramesPerCol    one-hot strobe, bit index col*MaxFramesPerCol+frame
//  busy             out  1                               high whenever state != IDLE
//  err              out  1                               sticky: malformed header seen
//  frames_written   out  16                              count of completed strobes, wraps 0xFFFF->0
// BEHAVIOUR
//  Handshake
//  - Word transfers on a rising CLK edge with s_valid && s_ready.
//  - s_ready is registered-state decoded: 1 in IDLE and LOAD, 0 otherwise.
//  Header word
//  - s_data[31:24] = 8'hFA sync; [23:16] = col; [15:8] = frame; [7:0] ignored.
//  States: IDLE -> LOAD -> SETUP -> STROBE -> HOLD -> IDLE
//  - IDLE: on header transfer, if sync==FA, col<NumberOfCols and frame<MaxFramesPerCol:
//    latch col/frame, clear row count, go to LOAD.
//    Otherwise consume the word, set err, stay in IDLE.
//  - LOAD: word k (k = 0..NumberOfRows-1) written to row k of FrameData.
//    On row NumberOfRows-1 go to SETUP. No sync check on data words.
//  - SETUP: 1 cycle, strobe low, FrameData stable.
//  - STROBE: FrameStrobe[col*MaxFramesPerCol+frame] = 1 for StrobeCycles cycles; all other bits 0.
//  - HOLD: 1 cycle, strobe low, FrameData unchanged.
//    frames_written increments on the HOLD entry edge.
//  Timing
//  - Relative to the edge accepting the last row word (edge 0):
//    SETUP in cycle 1, strobe high in cycles 2..1+StrobeCycles, HOLD in cycle 2+StrobeCycles,
//    IDLE with s_ready=1 in cycle 3+StrobeCycles.
//  - Minimum frame period: NumberOfRows+1 transfer cycles + StrobeCycles + 2.
//  Output integrity
//  - FrameData only changes in LOAD. Between frames it retains the last frame.
//    It never changes while any strobe bit is high, or in the cycle before or after one.
//  - FrameStrobe is driven directly from flops: no combinational path from inputs, glitch-free, never >1 bit set.
//  Reset values (async on RESET=1, including mid-LOAD or mid-STROBE)
//  - State = IDLE; FrameStrobe = 0 immediately; FrameData = 0; s_ready = 0 while RESET=1; busy = 0; err = 0; frames_written = 0.
//  - Partially loaded frame is discarded, never strobed.
//  - err clears only on RESET.
//  Boundaries
//  - s_valid low in LOAD: wait indefinitely, state held.
//  - col = NumberOfCols-1 and frame = MaxFramesPerCol-1 legal: top strobe bit.
//  - Header arriving while busy is not accepted (s_ready=0), so the source holds it.
// TESTING
//  T1 Reset: assert RESET mid-STROBE -> FrameStrobe=0 same cycle; all outputs at reset values; next frame works.
//  T2 Nominal: header 0xFA020300, rows 0x00000000..0x0000000F ->
//     FrameData row r = r; only FrameStrobe[2*20+3]=FrameStrobe[43] high 1 cycle, 2 cycles after last row; frames_written=1.
//  T3 Bad headers: 0xFB000000, 0xFA080000, 0xFA001400 ->
//     each consumed with s_ready=1, err=1, no strobe, busy stays 0.
//  T4 Backpressure: random s_valid gaps in LOAD ->
//     identical FrameData/strobe to T2; s_ready low SETUP..HOLD; header offered during HOLD accepted only in IDLE.
//  T5 Edges: col 7 frame 19, StrobeCycles=3 -> FrameStrobe[159] high exactly 3 cycles; FrameData stable from SETUP through HOLD.
//  T6 Wrap: preload 65535 frames (force) then one frame -> frames_written=0.

Source files
------------

// File: rtl/frame_config_writer.sv
// Purpose : writer side of the tile configuration-frame interface. It takes one
//           header word and NumberOfRows row words, assembles them into FrameData,
//           then pulses one FrameStrobe line for the column and frame in the header.
// Latency : the cycle after the last row is SETUP, the strobe is high for StrobeCycles
//           cycles, then comes one HOLD cycle, and s_ready returns one cycle after HOLD.
// Backpressure: s_ready is high only in IDLE and LOAD, and low while RESET is high. The
//           source holds a word until it is accepted. LOAD waits indefinitely for data.
//
// Ports:
//   CLK, RESET      rising-edge clock, asynchronous active-high reset
//   s_data/s_valid  32-bit word stream in; s_ready out (decoded from registered state)
//   FrameData       row r at [r*FrameBitsPerRow +: FrameBitsPerRow]; holds the last frame
//   FrameStrobe     one-hot, bit col*MaxFramesPerCol+frame, driven straight from flops
//   busy            high whenever the writer is not IDLE
//   err             sticky flag for a malformed header; cleared only by RESET
//   frames_written  count of completed strobes; wraps from 0xFFFF to 0
module frame_config_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfCols    = 8,
    parameter int StrobeCycles    = 1
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic [31:0]                             s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    busy,
    output logic                                    err,
    output logic [15:0]                             frames_written
);

    localparam int RW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int SW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam int NS = NumberOfCols * MaxFramesPerCol;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q;
    logic [7:0]      col_q;
    logic [7:0]      frm_q;
    logic [SW-1:0]   scnt_q;
    logic [15:0]     fw_q;

    logic            xfer;
    logic            hdr_ok;
    logic            hdr_take;
    logic            bad_hdr;
    logic            load_row;
    logic            strobe_last;
    logic            strobe_on;
    logic            fw_inc;
    logic [NS-1:0]   strobe_d;

    // RESET gates s_ready as well: the async reset forces IDLE, which would
    // otherwise advertise ready while the block is still held in reset.
    assign s_ready        = !RESET && ((state_q == IDLE) || (state_q == LOAD));
    assign busy           = (state_q != IDLE);
    assign frames_written = fw_q;
    assign xfer           = s_valid && s_ready;

    // Column and frame are compared at 9 bits so that a count of 256 still fits.
    assign hdr_ok = (s_data[31:24] == 8'hFA)
                 && ({1'b0, s_data[23:16]} < 9'(NumberOfCols))
                 && ({1'b0, s_data[15:8]}  < 9'(MaxFramesPerCol));

    assign strobe_last = (scnt_q == SW'(StrobeCycles - 1));

    // The strobe flop is loaded from state alone. The cycle the strobe rises is
    // the cycle that follows SETUP, and it stays high until the last STROBE
    // cycle ends, so no input can reach FrameStrobe through combinational logic.
    assign strobe_on = (state_q == SETUP) || ((state_q == STROBE) && !strobe_last);
    assign fw_inc    = (state_q == STROBE) && strobe_last;

    always_comb begin
        state_d  = state_q;
        hdr_take = 1'b0;
        bad_hdr  = 1'b0;
        load_row = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        hdr_take = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        bad_hdr = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    load_row = 1'b1;
                    if (row_q == RW'(NumberOfRows - 1)) begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP:   state_d = STROBE;
            STROBE:  if (strobe_last) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One-hot decode of the latched column and frame. A bit is set only while
    // the strobe window is active.
    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < NumberOfCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                strobe_d[c*MaxFramesPerCol + f] = strobe_on
                                                && (col_q == 8'(c))
                                                && (frm_q == 8'(f));
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            frm_q       <= '0;
            scnt_q      <= '0;
            fw_q        <= '0;
            err         <= 1'b0;
            FrameData   <= '0;
            FrameStrobe <= '0;
        end else begin
            state_q     <= state_d;
            FrameStrobe <= strobe_d;

            if (hdr_take) begin
                col_q <= s_data[23:16];
                frm_q <= s_data[15:8];
                row_q <= '0;
            end else if (load_row) begin
                row_q <= row_q + RW'(1);
            end

            scnt_q <= (state_q == STROBE) ? scnt_q + SW'(1) : '0;

            // FrameData changes only on accepted LOAD words, so it is stable
            // from SETUP through HOLD and holds its value between frames.
            for (int r = 0; r < NumberOfRows; r++) begin
                if (load_row && (row_q == RW'(r))) begin
                    FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                end
            end

            if (bad_hdr) begin
                err <= 1'b1;
            end

            if (fw_inc) begin
                fw_q <= fw_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_config_writer.sv
// Bench for frame_config_writer. It drives two instances, one with StrobeCycles=1
// and one with StrobeCycles=3. A shared stimulus driver feeds whichever instance
// 'sel' points at. Expected values come from a frame-level model.
module tb_frame_config_writer;

    localparam int W = 32;
    localparam int M = 20;
    localparam int R = 16;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    s_data;
    logic           s_valid;
    logic           sel;

    logic           v1, v3, r1, r3, b1, b3, e1, e3;
    logic [R*W-1:0] fd1, fd3;
    logic [C*M-1:0] st1, st3;
    logic [15:0]    fw1, fw3;

    logic           rdy, bsy, er;
    logic [R*W-1:0] fd;
    logic [C*M-1:0] st;
    logic [15:0]    fw;

    always #5 clk = ~clk;

    assign v1  = s_valid & ~sel;
    assign v3  = s_valid & sel;
    assign rdy = sel ? r3  : r1;
    assign bsy = sel ? b3  : b1;
    assign er  = sel ? e3  : e1;
    assign fd  = sel ? fd3 : fd1;
    assign st  = sel ? st3 : st1;
    assign fw  = sel ? fw3 : fw1;

    frame_config_writer #(.StrobeCycles(1)) dut1 (
        .CLK(clk), .RESET(rst), .s_data(s_data), .s_valid(v1), .s_ready(r1),
        .FrameData(fd1), .FrameStrobe(st1), .busy(b1), .err(e1), .frames_written(fw1)
    );

    frame_config_writer #(.StrobeCycles(3)) dut3 (
        .CLK(clk), .RESET(rst), .s_data(s_data), .s_valid(v3), .s_ready(r3),
        .FrameData(fd3), .FrameStrobe(st3), .busy(b3), .err(e3), .frames_written(fw3)
    );

    int             n_vec = 0;
    int             n_bad = 0;
    logic [R*W-1:0] exp_fd  [2];
    logic           exp_err [2];
    logic [15:0]    exp_fw  [2];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    // Offer one word after a random idle gap, then wait (bounded) for the transfer.
    task automatic put_word(input logic [31:0] w, input int gapmax);
        int gap  = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        bit done = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (rdy) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 s_valid = 1'b0;
        if (!done) chk("rdy_timeout", 0, 1);
    endtask

    // Send a header and the first nrows rows. Rows are r (seq) or random.
    task automatic load_frame(input int col, input int frm, input bit seq,
                              input int gapmax, input int nrows);
        logic [31:0] w;
        put_word({8'hFA, 8'(col), 8'(frm), 8'($urandom)}, gapmax);
        for (int r = 0; r < nrows; r++) begin
            w = seq ? 32'(r) : $urandom;
            put_word(w, gapmax);
            exp_fd[sel][r*W +: W] = w;
        end
    endtask

    // Check the cycles after the last row: SETUP, strobe window, HOLD, IDLE.
    // A bad-sync word is offered the whole time and must not be taken before IDLE.
    task automatic check_tail(input int col, input int frm);
        int             S   = sel ? 3 : 1;
        logic [15:0]    fw0 = exp_fw[sel];
        logic [C*M-1:0] oh  = '0;
        logic [C*M-1:0] zero = '0;
        oh[col*M + frm] = 1'b1;
        s_data  = 32'hFB00_0000;
        s_valid = 1'b1;
        for (int c = 1; c <= S + 3; c++) begin
            @(negedge clk);
            if (c == S + 2) exp_fw[sel] = fw0 + 16'd1;
            chk("strobe",  st,  (c >= 2 && c <= S + 1) ? oh : zero);
            chk("fdata",   fd,  exp_fd[sel]);
            chk("s_ready", rdy, (c == S + 3));
            chk("busy",    bsy, (c != S + 3));
            chk("fcount",  fw,  exp_fw[sel]);
            chk("err",     er,  exp_err[sel]);
        end
        s_valid = 1'b0;
    endtask

    task automatic do_frame(input int col, input int frm, input bit seq, input int gapmax);
        load_frame(col, frm, seq, gapmax, R);
        check_tail(col, frm);
    endtask

    task automatic send_bad(input logic [31:0] w, input int gapmax);
        logic [C*M-1:0] zero = '0;
        put_word(w, gapmax);
        exp_err[sel] = 1'b1;
        @(negedge clk);
        chk("bad_err",    er,  1);
        chk("bad_busy",   bsy, 0);
        chk("bad_strobe", st,  zero);
        chk("bad_ready",  rdy, 1);
        chk("bad_fcount", fw,  exp_fw[sel]);
        chk("bad_fdata",  fd,  exp_fd[sel]);
    endtask

    function automatic logic [31:0] rand_bad();
        logic [31:0] w = $urandom;
        case ($urandom % 3)
            0:       w[31:24] = 8'hFA ^ 8'($urandom_range(255, 1));
            1:       begin w[31:24] = 8'hFA; w[23:16] = 8'($urandom_range(255, C)); end
            default: begin w[31:24] = 8'hFA; w[23:16] = 8'($urandom_range(C-1, 0));
                           w[15:8] = 8'($urandom_range(255, M)); end
        endcase
        return w;
    endfunction

    task automatic do_reset();
        logic [R*W-1:0] zfd = '0;
        logic [C*M-1:0] zst = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_strobe1", st1, zst); chk("rst_strobe3", st3, zst);
        chk("rst_fdata1",  fd1, zfd); chk("rst_fdata3",  fd3, zfd);
        chk("rst_ready1",  r1,  0);   chk("rst_ready3",  r3,  0);
        chk("rst_busy1",   b1,  0);   chk("rst_busy3",   b3,  0);
        chk("rst_err1",    e1,  0);   chk("rst_err3",    e3,  0);
        chk("rst_fcount1", fw1, 0);   chk("rst_fcount3", fw3, 0);
        for (int i = 0; i < 2; i++) begin
            exp_fd[i]  = '0;
            exp_err[i] = 1'b0;
            exp_fw[i]  = '0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_traffic(input int n);
        int col, frm;
        for (int i = 0; i < n; i++) begin
            if ($urandom % 4 == 0) begin
                send_bad(rand_bad(), 2);
            end else begin
                col = ($urandom % 4 == 0) ? C - 1 : int'($urandom_range(C - 1, 0));
                frm = ($urandom % 4 == 0) ? M - 1 : int'($urandom_range(M - 1, 0));
                do_frame(col, frm, 1'b0, int'($urandom_range(3, 0)));
            end
        end
    endtask

    initial begin
        logic [C*M-1:0] oh;
        logic [C*M-1:0] zst = '0;
        rst     = 1'b1;
        sel     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        do_reset();

        // Nominal frame: rows 0..15 land at column 2, frame 3, and strobe bit 43 fires.
        do_frame(2, 3, 1'b1, 0);

        // Malformed headers are consumed and set the sticky err flag.
        send_bad(32'hFB00_0000, 0);
        send_bad(32'hFA08_0000, 0);
        send_bad(32'hFA00_1400, 0);

        // The same frame again, with gaps in s_valid during LOAD.
        do_frame(2, 3, 1'b1, 3);
        rand_traffic(30);

        // Top strobe bit on the instance with StrobeCycles=3, then random frames.
        sel = 1'b1;
        do_frame(C - 1, M - 1, 1'b1, 2);
        rand_traffic(8);

        // Reset while the strobe is high clears it in the same cycle.
        sel = 1'b0;
        load_frame(2, 3, 1'b0, 0, R);
        @(negedge clk);
        @(negedge clk);
        oh = '0;
        oh[2*M + 3] = 1'b1;
        chk("pre_rst_strobe", st1, oh);
        do_reset();
        do_frame(4, 11, 1'b0, 1);

        // Reset in the middle of LOAD throws away the partial frame.
        sel = 1'b1;
        load_frame(5, 5, 1'b0, 1, 5);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("partial_strobe", st3, zst);
            chk("partial_busy",   b3,  0);
        end
        do_frame(1, 0, 1'b0, 0);

        // The frame counter wraps from 0xFFFF to 0.
        sel = 1'b0;
        @(negedge clk);
        force dut1.fw_q = 16'hFFFF;
        @(negedge clk);
        release dut1.fw_q;
        exp_fw[0] = 16'hFFFF;
        @(negedge clk);
        chk("fw_preload", fw1, 16'hFFFF);
        do_frame(0, 0, 1'b0, 0);
        chk("fw_wrapped", fw1, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
